// File: rtl/target_round_ctrl_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package target_round_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW,
    ST_REPORT,
    ST_RELEASE
  } state_t;

  localparam logic [1:0] RES_HIT     = 2'b00;
  localparam logic [1:0] RES_WRONG   = 2'b01;
  localparam logic [1:0] RES_TIMEOUT = 2'b10;

  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_GAP_MS    = 300;
  localparam int DEF_WIN_L1_MS = 1500;
  localparam int DEF_WIN_L2_MS = 1000;
  localparam int DEF_WIN_L3_MS = 600;
  localparam int DEF_DEB_MS    = 8;

  // Wide enough for the longest strike window at the default timing.
  localparam int CNT_W = 12;
endpackage

// File: rtl/target_round_ctrl_if.sv
// Result record handshake between the round sequencer and the scoring logic.
interface target_round_ctrl_if;
  logic       result_valid;
  logic [1:0] result_code;
  logic [1:0] result_box;
  logic       result_ready;

  modport master (output result_valid, result_code, result_box, input result_ready);
  modport slave  (input result_valid, result_code, result_box, output result_ready);
endinterface

// File: rtl/target_round_ctrl_sensor_debounce.sv
// Tick-driven stability filter: a sensor reading counts once unchanged for DEB_MS ticks.
module target_round_ctrl_sensor_debounce #(
  parameter int DEB_MS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic       raw_valid,
  input  logic [1:0] raw_box,
  output logic       stable_valid,
  output logic [1:0] stable_box,
  output logic       stable_idle
);
  localparam int DW = $clog2(DEB_MS + 1);

  logic          last_valid;
  logic [1:0]    last_box;
  logic [DW-1:0] cnt;
  logic          changed;
  logic          settled;

  // The box index only matters while something is actually being struck.
  assign changed = (raw_valid != last_valid) || (raw_valid && (raw_box != last_box));
  assign settled = (cnt == '0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_box   <= 2'b00;
      cnt        <= DW'(DEB_MS);
    end else if (clear || changed) begin
      last_valid <= raw_valid;
      last_box   <= raw_box;
      cnt        <= DW'(DEB_MS);
    end else if (tick && !settled) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign stable_valid = settled && last_valid;
  assign stable_idle  = settled && !last_valid;
  assign stable_box   = last_box;
endmodule

// File: rtl/target_round_ctrl.sv
// Round sequencer: picks a target box, lights it, waits for a strike or timeout,
// and hands one result record per round to the scoring logic.
//   state      | meaning
//   ST_IDLE    | game stopped, everything dark
//   ST_GAP     | dark pause before the next target
//   ST_SHOW    | target lit, waiting for a debounced strike or window expiry
//   ST_REPORT  | result record offered until accepted
//   ST_RELEASE | waiting for the sensor to read idle before the next round
module target_round_ctrl
  import target_round_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GAP_MS    = DEF_GAP_MS,
  parameter int WIN_L1_MS = DEF_WIN_L1_MS,
  parameter int WIN_L2_MS = DEF_WIN_L2_MS,
  parameter int WIN_L3_MS = DEF_WIN_L3_MS,
  parameter int DEB_MS    = DEF_DEB_MS
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_game,
  input  logic [1:0] difficulty_level,
  input  logic [2:0] lfsr_value,
  input  logic       sensor_valid,
  input  logic [1:0] sensor_box,
  output logic [3:0] target_led,
  output logic       play_sound,
  output logic       round_busy,
  target_round_ctrl_if.master res
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t           state;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_load;
  logic [1:0]       target;
  logic [1:0]       prev_target;
  logic [1:0]       pick;
  logic             deb_clear;
  logic             stable_valid;
  logic             stable_idle;
  logic [1:0]       stable_box;
  logic             unused_lfsr_msb;

  assign unused_lfsr_msb = lfsr_value[2];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Never light the same box twice in a row.
  assign pick = (lfsr_value[1:0] == prev_target) ? lfsr_value[1:0] + 2'd1 : lfsr_value[1:0];

  always_comb begin
    case (difficulty_level)
      2'd2:    win_load = CNT_W'(WIN_L2_MS);
      2'd3:    win_load = CNT_W'(WIN_L3_MS);
      default: win_load = CNT_W'(WIN_L1_MS);
    endcase
  end

  // Holding the filter cleared outside SHOW/RELEASE forces a fresh stability window on entry.
  assign deb_clear = (state != ST_SHOW) && (state != ST_RELEASE);

  target_round_ctrl_sensor_debounce #(.DEB_MS(DEB_MS)) u_debounce (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .clear        (deb_clear),
    .tick         (tick),
    .raw_valid    (sensor_valid),
    .raw_box      (sensor_box),
    .stable_valid (stable_valid),
    .stable_box   (stable_box),
    .stable_idle  (stable_idle)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state            <= ST_IDLE;
      gap_cnt          <= '0;
      win_cnt          <= '0;
      target           <= 2'b00;
      prev_target      <= 2'b00;
      target_led       <= 4'b0000;
      play_sound       <= 1'b0;
      round_busy       <= 1'b0;
      res.result_valid <= 1'b0;
      res.result_code  <= 2'b00;
      res.result_box   <= 2'b00;
    end else begin
      play_sound <= 1'b0;
      case (state)
        ST_IDLE: begin
          target_led <= 4'b0000;
          if (start_game) begin
            gap_cnt    <= CNT_W'(GAP_MS);
            round_busy <= 1'b1;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!start_game) begin
            round_busy <= 1'b0;
            state      <= ST_IDLE;
          end else if (gap_cnt == '0) begin
            target      <= pick;
            prev_target <= pick;
            win_cnt     <= win_load;
            target_led  <= 4'b0001 << pick;
            state       <= ST_SHOW;
          end else if (tick) begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (!start_game) begin
            target_led <= 4'b0000;
            round_busy <= 1'b0;
            state      <= ST_IDLE;
          end else if (stable_valid || (win_cnt == '0)) begin
            // A strike that settles on the expiry tick still counts as a strike.
            res.result_code  <= !stable_valid ? RES_TIMEOUT :
                                (stable_box == target) ? RES_HIT : RES_WRONG;
            res.result_box   <= target;
            res.result_valid <= 1'b1;
            target_led       <= 4'b0000;
            state            <= ST_REPORT;
          end else if (tick) begin
            win_cnt <= win_cnt - CNT_W'(1);
          end
        end
        ST_REPORT: begin
          if (res.result_ready) begin
            res.result_valid <= 1'b0;
            play_sound       <= (res.result_code == RES_HIT);
            state            <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (stable_idle) begin
            if (start_game) begin
              gap_cnt <= CNT_W'(GAP_MS);
              state   <= ST_GAP;
            end else begin
              round_busy <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          round_busy <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_target_round_ctrl.sv
// Scoreboard bench for target_round_ctrl: directed rounds push expected records,
// a monitor pops and checks them on every result handshake.
module tb_target_round_ctrl;
  import target_round_ctrl_pkg::*;

  localparam int TD = 4;

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] box;
  } exp_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start_game = 1'b0;
  logic [1:0] difficulty_level = 2'd1;
  logic [2:0] lfsr_value = 3'b000;
  logic       sensor_valid = 1'b0;
  logic [1:0] sensor_box = 2'b00;
  logic [3:0] target_led;
  logic       play_sound;
  logic       round_busy;

  target_round_ctrl_if res_if ();

  target_round_ctrl #(
    .TICK_DIV (TD), .GAP_MS (3), .WIN_L1_MS (10), .WIN_L2_MS (7),
    .WIN_L3_MS (5), .DEB_MS (2)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .start_game       (start_game),
    .difficulty_level (difficulty_level),
    .lfsr_value       (lfsr_value),
    .sensor_valid     (sensor_valid),
    .sensor_box       (sensor_box),
    .target_led       (target_led),
    .play_sound       (play_sound),
    .round_busy       (round_busy),
    .res              (res_if)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int   n_checks = 0;
  int   n_pass = 0;
  int   hs_count = 0;
  int   n_pushed = 0;
  exp_t exp_q[$];
  bit   snd_pending = 0;
  bit   snd_after = 0;
  bit   snd_exp = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, wanted %0d", nm, act, req);
  endtask

  task automatic push(input logic [1:0] code, input logic [1:0] box);
    exp_t e;
    e.code = code;
    e.box  = box;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic wait_led(input logic [3:0] req, input int lo, input int hi, input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      cyc(1);
      n++;
      if (target_led != 4'b0000) seen = 1;
    end
    chk(seen, {nm, "_seen"}, n, hi);
    chk(target_led == req, {nm, "_value"}, int'(target_led), int'(req));
    chk(n >= lo && n <= hi, {nm, "_latency"}, n, lo);
  endtask

  task automatic wait_valid(input int lo, input int hi, input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      cyc(1);
      n++;
      if (res_if.result_valid) seen = 1;
    end
    chk(seen, {nm, "_seen"}, n, hi);
    chk(n >= lo && n <= hi, {nm, "_latency"}, n, lo);
  endtask

  task automatic check_all_zero(input string nm);
    chk(target_led == 4'b0000, {nm, "_led"}, int'(target_led), 0);
    chk(res_if.result_valid == 1'b0, {nm, "_valid"}, int'(res_if.result_valid), 0);
    chk(res_if.result_code == 2'b00, {nm, "_code"}, int'(res_if.result_code), 0);
    chk(res_if.result_box == 2'b00, {nm, "_box"}, int'(res_if.result_box), 0);
    chk(play_sound == 1'b0, {nm, "_sound"}, int'(play_sound), 0);
    chk(round_busy == 1'b0, {nm, "_busy"}, int'(round_busy), 0);
  endtask

  // Monitor: checks every accepted record and the play_sound pulse that follows it.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (snd_pending) begin
        chk(play_sound == snd_exp, "play_sound_pulse", int'(play_sound), int'(snd_exp));
        chk(res_if.result_valid == 1'b0, "valid_drop", int'(res_if.result_valid), 0);
        snd_pending = 0;
        snd_after   = 1;
      end else if (snd_after) begin
        chk(play_sound == 1'b0, "play_sound_width", int'(play_sound), 0);
        snd_after = 0;
      end else begin
        chk(play_sound == 1'b0, "play_sound_idle", int'(play_sound), 0);
      end
      if (res_if.result_valid && res_if.result_ready) begin
        hs_count++;
        chk(exp_q.size() != 0, "record_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk(res_if.result_code == e.code, "record_code", int'(res_if.result_code), int'(e.code));
          chk(res_if.result_box == e.box, "record_box", int'(res_if.result_box), int'(e.box));
          snd_exp     = (e.code == RES_HIT);
          snd_pending = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    bit idle_seen;
    res_if.result_ready = 1'b1;
    cyc(3);
    check_all_zero("reset");
    reset = 1'b0;

    // Round A: hit on box 2, zero-wait handshake.
    lfsr_value = 3'b110;
    start_game = 1'b1;
    wait_led(4'b0100, 11, 14, "rA_led");
    chk(round_busy == 1'b1, "rA_busy", int'(round_busy), 1);
    push(RES_HIT, 2'd2);
    sensor_valid = 1'b1;
    sensor_box   = 2'd2;
    wait_valid(7, 10, "rA_strike");
    sensor_valid = 1'b0;

    // Round B: no strike, difficulty 1 timeout on box 1.
    lfsr_value = 3'b001;
    wait_led(4'b0010, 1, 300, "rB_led");
    push(RES_TIMEOUT, 2'd1);
    wait_valid(38, 41, "rB_timeout");

    // Round C: short glitch on the target, then a wrong-box strike held against ready=0.
    lfsr_value = 3'b011;
    wait_led(4'b1000, 1, 300, "rC_led");
    sensor_valid = 1'b1;
    sensor_box   = 2'd3;
    vcnt = 0;
    repeat (4) begin
      cyc(1);
      if (res_if.result_valid) vcnt++;
    end
    sensor_valid = 1'b0;
    repeat (6) begin
      cyc(1);
      if (res_if.result_valid) vcnt++;
    end
    chk(vcnt == 0, "rC_glitch_ignored", vcnt, 0);
    res_if.result_ready = 1'b0;
    push(RES_WRONG, 2'd3);
    sensor_valid = 1'b1;
    sensor_box   = 2'd1;
    wait_valid(7, 10, "rC_strike");
    sensor_valid = 1'b0;
    chk(target_led == 4'b0000, "rC_led_dark", int'(target_led), 0);
    for (int i = 0; i < 20; i++) begin
      chk(res_if.result_valid == 1'b1, "rC_hold_valid", int'(res_if.result_valid), 1);
      chk(res_if.result_code == RES_WRONG, "rC_hold_code", int'(res_if.result_code), int'(RES_WRONG));
      chk(res_if.result_box == 2'd3, "rC_hold_box", int'(res_if.result_box), 3);
      cyc(1);
    end
    chk(round_busy == 1'b1, "rC_busy", int'(round_busy), 1);
    lfsr_value       = 3'b001;
    difficulty_level = 2'd2;
    res_if.result_ready = 1'b1;

    // Round D: box 1, difficulty 2 latched at show; mid-round change ignored.
    wait_led(4'b0010, 1, 300, "rD_led");
    difficulty_level = 2'd3;
    push(RES_TIMEOUT, 2'd1);
    wait_valid(26, 29, "rD_timeout");
    difficulty_level = 2'd0;

    // Round E: same lfsr again must move to box 2; then start_game drops mid-show.
    wait_led(4'b0100, 1, 300, "rE_led");
    cyc(2);
    start_game = 1'b0;
    cyc(1);
    chk(target_led == 4'b0000, "rE_abort_led", int'(target_led), 0);
    chk(round_busy == 1'b0, "rE_abort_busy", int'(round_busy), 0);
    vcnt = 0;
    repeat (50) begin
      if (res_if.result_valid) vcnt++;
      cyc(1);
    end
    chk(vcnt == 0, "rE_no_record", vcnt, 0);

    // Round F: record pending in REPORT is discarded by reset.
    lfsr_value = 3'b011;
    res_if.result_ready = 1'b0;
    start_game = 1'b1;
    wait_led(4'b1000, 11, 14, "rF_led");
    sensor_valid = 1'b1;
    sensor_box   = 2'd1;
    wait_valid(7, 10, "rF_strike");
    chk(res_if.result_code == RES_WRONG, "rF_code_before_reset", int'(res_if.result_code), int'(RES_WRONG));
    reset = 1'b1;
    cyc(1);
    check_all_zero("rF_reset");
    sensor_valid = 1'b0;
    start_game   = 1'b0;
    res_if.result_ready = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Round G: prev_target cleared by reset, difficulty 0 acts as level 1, then stop.
    lfsr_value = 3'b000;
    start_game = 1'b1;
    wait_led(4'b0010, 11, 14, "rG_led");
    push(RES_TIMEOUT, 2'd1);
    wait_valid(38, 41, "rG_timeout");
    start_game = 1'b0;
    idle_seen = 0;
    for (int i = 0; i < 40 && !idle_seen; i++) begin
      cyc(1);
      if (!round_busy) idle_seen = 1;
    end
    chk(idle_seen, "rG_release_to_idle", int'(round_busy), 0);
    cyc(12);
    chk(round_busy == 1'b0, "rG_stays_idle", int'(round_busy), 0);
    chk(target_led == 4'b0000, "rG_led_dark", int'(target_led), 0);

    cyc(3);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(hs_count == n_pushed, "record_count", hs_count, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
